hsv_adjust: RTL and testbench

Parametrised successor to the frame-synchronous S/V enhancement stage. It applies user-controlled offsets to all three HSV components. Hue wraps modulo 2^DW; saturation and value use saturating signed offsets. Held buttons accelerate the offset step, and a valid-qualified 2-stage pipeline sits between the RGB→HSV converter and the HSV→RGB converter in the pixel path.

---
 rtl/hsv_pkg.sv | 27 ++
 rtl/hsv_chan_adj.sv | 44 ++++
 rtl/hsv_adjust.sv | 173 +++++++++++++++++
 tb/tb_hsv_adjust.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared constants, hold-state encoding and the accelerated-step rule
// for the HSV offset adjuster.
package hsv_pkg;

    localparam logic [1:0] CH_H    = 2'd0;
    localparam logic [1:0] CH_S    = 2'd1;
    localparam logic [1:0] CH_V    = 2'd2;
    localparam logic [1:0] CH_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_INC = 2'd1,
        HOLD_DEC = 2'd2
    } hold_state_e;

    // Step doubles every accel_frames held frames, capped at max_shift doublings.
    function automatic int unsigned step_of(input int unsigned hcnt,
                                            input int unsigned base_step,
                                            input int unsigned accel_frames,
                                            input int unsigned max_shift);
        int unsigned shift;
        shift = hcnt / accel_frames;
        if (shift > max_shift) shift = max_shift;
        return base_step << shift;
    endfunction

endpackage

// File: rtl/hsv_chan_adj.sv
// Two-stage add/limit for one HSV component: stage 1 registers the extended
// sum, stage 2 wraps (WRAP=1) or clamps to [0, 2^DW-1] (WRAP=0).
module hsv_chan_adj #(
    parameter int unsigned DW   = 8,
    parameter bit          WRAP = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] comp_i,
    input  logic [DW:0]   off_i,
    output logic [DW-1:0] comp_o
);

    // A wrapping channel only needs the low DW bits of the sum.
    localparam int unsigned SW = WRAP ? DW : DW + 2;

    logic [SW-1:0] sum_d, sum_q;
    logic [DW-1:0] comp_d, comp_q;

    assign sum_d = SW'({2'b00, comp_i} + {off_i[DW], off_i});

    if (WRAP) begin : g_wrap
        assign comp_d = sum_q[DW-1:0];
    end else begin : g_sat
        always_comb begin
            if (sum_q[DW+1])  comp_d = '0;
            else if (sum_q[DW]) comp_d = '1;
            else              comp_d = sum_q[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            comp_q <= '0;
        end else begin
            sum_q  <= sum_d;
            comp_q <= comp_d;
        end
    end

    assign comp_o = comp_q;

endmodule

// File: rtl/hsv_adjust.sv
// Frame-synchronous H/S/V offset adjuster: vsync edge detect, button hold
// FSM with step acceleration, offset registers and a 2-stage pixel path.
module hsv_adjust
    import hsv_pkg::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned STEP         = 1,
    parameter int unsigned ACCEL_FRAMES = 16,
    parameter int unsigned MAX_SHIFT    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vsync,
    input  logic            enhance_en,
    input  logic [1:0]      sel,
    input  logic            inc,
    input  logic            dec,
    input  logic            clear,
    input  logic            pix_valid_in,
    input  logic [3*DW-1:0] hsv_in,
    output logic            pix_valid_out,
    output logic [3*DW-1:0] hsv_out,
    output logic [DW-1:0]   off_h,
    output logic [DW:0]     off_s,
    output logic [DW:0]     off_v,
    output hold_state_e     dbg_hold_state_o
);

    localparam int unsigned HCNT_MAX = ACCEL_FRAMES * MAX_SHIFT;
    localparam int unsigned HCW      = (HCNT_MAX > 0) ? $clog2(HCNT_MAX + 1) : 1;
    localparam logic signed [DW+1:0] SV_LIM = (DW+2)'((1 << DW) - 1);
    localparam logic [DW:0] OFF_POS = (DW+1)'((1 << DW) - 1);
    localparam logic [DW:0] OFF_NEG = ~OFF_POS + 1'b1;

    logic                 vsync_q, vfall, upd, press_inc, press_dec, hold_match;
    logic [DW-1:0]        off_h_q, off_h_d;
    logic [DW:0]          off_s_q, off_s_d, off_v_q, off_v_d;
    hold_state_e          hold_q, hold_d;
    logic [1:0]           hold_sel_q, hold_sel_d;
    logic [HCW-1:0]       hcnt_q, hcnt_d, hcnt_base;
    logic [DW:0]          step_val;
    logic signed [DW+1:0] sv_ext, step_ext, sv_sum;
    logic [DW:0]          sv_new;
    logic [1:0]           valid_q;
    logic [DW:0]          pix_off_h, pix_off_s, pix_off_v;

    assign vfall     = vsync_q & ~vsync;
    assign upd       = vfall & enhance_en & ~clear & (sel != CH_NONE);
    assign press_inc = inc & ~dec;
    assign press_dec = dec & ~inc;

    // Only a repeat of the same direction on the same channel keeps accelerating.
    assign hold_match = (sel == hold_sel_q) &&
                        ((hold_q == HOLD_INC && press_inc) || (hold_q == HOLD_DEC && press_dec));
    assign hcnt_base  = hold_match ? hcnt_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            hold_q     <= IDLE;
            hold_sel_q <= CH_H;
            hcnt_q     <= '0;
            off_h_q    <= '0;
            off_s_q    <= '0;
            off_v_q    <= '0;
            valid_q    <= '0;
        end else begin
            vsync_q    <= vsync;
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
            hcnt_q     <= hcnt_d;
            off_h_q    <= off_h_d;
            off_s_q    <= off_s_d;
            off_v_q    <= off_v_d;
            valid_q    <= {valid_q[0], pix_valid_in};
        end
    end

    always_comb begin
        hold_d     = hold_q;
        hold_sel_d = hold_sel_q;
        hcnt_d     = hcnt_q;
        if (clear) begin
            hold_d     = IDLE;
            hold_sel_d = CH_H;
            hcnt_d     = '0;
        end else if (upd) begin
            if (press_inc || press_dec) begin
                hold_d     = press_inc ? HOLD_INC : HOLD_DEC;
                hold_sel_d = sel;
                hcnt_d     = (hcnt_base == HCW'(HCNT_MAX)) ? hcnt_base : hcnt_base + 1'b1;
            end else begin
                hold_d = IDLE;
                hcnt_d = '0;
            end
        end
    end

    always_comb begin
        step_val         = (DW+1)'(step_of(32'(hcnt_base), STEP, ACCEL_FRAMES, MAX_SHIFT));
        dbg_hold_state_o = hold_q;
    end

    always_comb begin
        off_h_d  = off_h_q;
        off_s_d  = off_s_q;
        off_v_d  = off_v_q;
        sv_ext   = (sel == CH_S) ? {off_s_q[DW], off_s_q} : {off_v_q[DW], off_v_q};
        step_ext = {1'b0, step_val};
        sv_sum   = press_inc ? sv_ext + step_ext : sv_ext - step_ext;
        if (sv_sum > SV_LIM)       sv_new = OFF_POS;
        else if (sv_sum < -SV_LIM) sv_new = OFF_NEG;
        else                       sv_new = sv_sum[DW:0];

        if (clear) begin
            off_h_d = '0;
            off_s_d = '0;
            off_v_d = '0;
        end else if (upd) begin
            if (inc && dec) begin
                case (sel)
                    CH_H:    off_h_d = '0;
                    CH_S:    off_s_d = '0;
                    CH_V:    off_v_d = '0;
                    default: ;
                endcase
            end else if (press_inc || press_dec) begin
                case (sel)
                    CH_H:    off_h_d = press_inc ? off_h_q + step_val[DW-1:0]
                                                 : off_h_q - step_val[DW-1:0];
                    CH_S:    off_s_d = sv_new;
                    CH_V:    off_v_d = sv_new;
                    default: ;
                endcase
            end
        end
    end

    // Next-state offsets feed the pixel path so a pixel sampled on the update edge sees them.
    assign pix_off_h = enhance_en ? {1'b0, off_h_d} : '0;
    assign pix_off_s = enhance_en ? off_s_d : '0;
    assign pix_off_v = enhance_en ? off_v_d : '0;

    hsv_chan_adj #(.DW(DW), .WRAP(1'b1)) u_chan_h (
        .clk    (clk),
        .rst    (rst),
        .comp_i (hsv_in[3*DW-1:2*DW]),
        .off_i  (pix_off_h),
        .comp_o (hsv_out[3*DW-1:2*DW])
    );

    hsv_chan_adj #(.DW(DW), .WRAP(1'b0)) u_chan_s (
        .clk    (clk),
        .rst    (rst),
        .comp_i (hsv_in[2*DW-1:DW]),
        .off_i  (pix_off_s),
        .comp_o (hsv_out[2*DW-1:DW])
    );

    hsv_chan_adj #(.DW(DW), .WRAP(1'b0)) u_chan_v (
        .clk    (clk),
        .rst    (rst),
        .comp_i (hsv_in[DW-1:0]),
        .off_i  (pix_off_v),
        .comp_o (hsv_out[DW-1:0])
    );

    assign pix_valid_out = valid_q[1];
    assign off_h         = off_h_q;
    assign off_s         = off_s_q;
    assign off_v         = off_v_q;

endmodule

// File: tb/tb_hsv_adjust.sv
// Bench for hsv_adjust: directed frame/button sequences with random pixel
// traffic, checked every cycle against a frame-level offset model.
module tb_hsv_adjust;

  localparam int DW    = 8;
  localparam int STEP  = 1;
  localparam int ACCEL = 4;
  localparam int MAXS  = 2;

  logic        clk, rst, vsync, enhance_en, inc, dec, clear, pix_valid_in;
  logic [1:0]  sel;
  logic [23:0] hsv_in;
  logic        pix_valid_out;
  logic [23:0] hsv_out;
  logic [7:0]  off_h;
  logic [8:0]  off_s, off_v;
  hsv_pkg::hold_state_e dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model state: offsets as plain integers, plus the length of the
  // current run of identical presses
  int m_off_h, m_off_s, m_off_v;
  int run_dir, run_sel, run_len;
  bit vs_prev;
  logic [24:0] exp_q[$];
  logic [24:0] exp_out;

  int acc_seq[10] = '{1, 2, 3, 4, 6, 8, 10, 12, 16, 20};

  hsv_adjust #(.DW(DW), .STEP(STEP), .ACCEL_FRAMES(ACCEL), .MAX_SHIFT(MAXS)) dut (
    .clk              (clk),
    .rst              (rst),
    .vsync            (vsync),
    .enhance_en       (enhance_en),
    .sel              (sel),
    .inc              (inc),
    .dec              (dec),
    .clear            (clear),
    .pix_valid_in     (pix_valid_in),
    .hsv_in           (hsv_in),
    .pix_valid_out    (pix_valid_out),
    .hsv_out          (hsv_out),
    .off_h            (off_h),
    .off_s            (off_s),
    .off_v            (off_v),
    .dbg_hold_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_pix(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic int sat_off(input int x);
    return (x < -255) ? -255 : ((x > 255) ? 255 : x);
  endfunction

  function automatic logic [23:0] pix_model(input logic [23:0] p, input logic en);
    int h, s, v;
    if (!en) return p;
    h = (int'(p[23:16]) + m_off_h) % 256;
    s = sat_pix(int'(p[15:8]) + m_off_s);
    v = sat_pix(int'(p[7:0]) + m_off_v);
    return {8'(h), 8'(s), 8'(v)};
  endfunction

  task automatic model_reset();
    m_off_h = 0; m_off_s = 0; m_off_v = 0;
    run_dir = 0; run_sel = 0; run_len = 0;
    vs_prev = 1'b0;
    exp_q = {};
    exp_q.push_back('0);
    exp_out = '0;
  endtask

  task automatic model_edge();
    bit vfall;
    int d, sh, st;
    if (rst) begin
      model_reset();
    end else begin
      vfall = vs_prev && !vsync;
      vs_prev = vsync;
      if (clear) begin
        m_off_h = 0; m_off_s = 0; m_off_v = 0;
        run_dir = 0; run_len = 0;
      end else if (vfall && enhance_en && sel != 2'd3) begin
        if (inc && dec) begin
          if (sel == 2'd0) m_off_h = 0;
          if (sel == 2'd1) m_off_s = 0;
          if (sel == 2'd2) m_off_v = 0;
          run_dir = 0; run_len = 0;
        end else if (inc || dec) begin
          d = inc ? 1 : -1;
          if (run_dir != d || run_sel != int'(sel)) begin
            run_dir = d; run_sel = int'(sel); run_len = 0;
          end
          sh = run_len / ACCEL;
          if (sh > MAXS) sh = MAXS;
          st = STEP << sh;
          run_len++;
          if (sel == 2'd0) m_off_h = (((m_off_h + d * st) % 256) + 256) % 256;
          if (sel == 2'd1) m_off_s = sat_off(m_off_s + d * st);
          if (sel == 2'd2) m_off_v = sat_off(m_off_v + d * st);
        end else begin
          run_dir = 0; run_len = 0;
        end
      end
      exp_q.push_back({pix_valid_in, pix_model(hsv_in, enhance_en)});
      exp_out = exp_q.pop_front();
    end
  endtask

  task automatic check_outputs();
    chk("off_h", 32'(off_h), 32'(m_off_h));
    chk("off_s", 32'(off_s), 32'(m_off_s) & 32'h1FF);
    chk("off_v", 32'(off_v), 32'(m_off_v) & 32'h1FF);
    chk("valid_out", 32'(pix_valid_out), 32'(exp_out[24]));
    chk("hsv_out", 32'(hsv_out), 32'(exp_out[23:0]));
  endtask

  task automatic tick(input bit rnd);
    if (rnd) begin
      pix_valid_in = 1'($urandom_range(0, 1));
      hsv_in = 24'($urandom);
    end
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic press(input logic [1:0] s, input bit i, input bit d);
    sel = s; inc = i; dec = d;
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
    tick(1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; enhance_en = 1'b1; sel = 2'd3;
    inc = 1'b0; dec = 1'b0; clear = 1'b0; pix_valid_in = 1'b0; hsv_in = '0;
    model_reset();
    #1;
    check_outputs();
    chk("reset_state", 32'(dbg_state), 32'(hsv_pkg::IDLE));
    tick(1);
    tick(1);
    rst = 1'b0;
    tick(1);

    // acceleration on S
    for (int i = 0; i < 10; i++) begin
      press(2'd1, 1'b1, 1'b0);
      chk("accel_seq", 32'(off_s), 32'(acc_seq[i]));
    end
    press(2'd1, 1'b0, 1'b0);
    chk("accel_release", 32'(off_s), 32'd20);

    // S/V saturation
    pulse_clear();
    while (m_off_s < 100) press(2'd1, 1'b1, 1'b0);
    chk("preload_s", 32'(off_s), 32'd100);
    repeat (10) press(2'd2, 1'b0, 1'b1);
    chk("preload_v", 32'(off_v), 32'h1EC);
    inc = 1'b0; dec = 1'b0;
    pix_valid_in = 1'b1;
    hsv_in = {8'd50, 8'd200, 8'd10};
    tick(0);
    tick(0);
    chk("sat_s_pix", 32'(hsv_out[15:8]), 32'd255);
    chk("sat_v_pix", 32'(hsv_out[7:0]), 32'd0);
    repeat (80) press(2'd2, 1'b0, 1'b1);
    chk("v_clamp_neg", 32'(off_v), 32'h101);

    // hue wrap
    pulse_clear();
    while (m_off_h < 10) press(2'd0, 1'b1, 1'b0);
    chk("preload_h", 32'(off_h), 32'd10);
    pix_valid_in = 1'b1;
    hsv_in = {8'd250, 8'd0, 8'd0};
    tick(0);
    tick(0);
    chk("h_wrap_up", 32'(hsv_out[23:16]), 32'd4);
    pulse_clear();
    press(2'd0, 1'b0, 1'b1);
    chk("h_wrap_dec", 32'(off_h), 32'd255);
    hsv_in = {8'd0, 8'd0, 8'd0};
    tick(0);
    tick(0);
    chk("h_wrap_pix", 32'(hsv_out[23:16]), 32'd255);

    // inc+dec zeroes the selected offset, clear zeroes everything
    repeat (3) press(2'd2, 1'b0, 1'b1);
    press(2'd2, 1'b1, 1'b1);
    chk("incdec_zero", 32'(off_v), 32'd0);
    chk("incdec_h_kept", 32'(off_h), 32'd255);
    repeat (2) press(2'd1, 1'b1, 1'b0);
    inc = 1'b0;
    pulse_clear();
    chk("clear_h", 32'(off_h), 32'd0);
    chk("clear_s", 32'(off_s), 32'd0);

    // clear coincident with vfall
    repeat (2) press(2'd1, 1'b1, 1'b0);
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_vfall", 32'(off_s), 32'd0);

    // bypass
    repeat (3) press(2'd1, 1'b1, 1'b0);
    press(2'd0, 1'b1, 1'b0);
    enhance_en = 1'b0;
    repeat (40) tick(1);
    pix_valid_in = 1'b1;
    hsv_in = 24'h123456;
    tick(0);
    pix_valid_in = 1'b0;
    hsv_in = 24'hABCDEF;
    tick(0);
    chk("bypass_data", 32'(hsv_out), 32'h123456);
    chk("bypass_valid", 32'(pix_valid_out), 32'd1);
    press(2'd1, 1'b1, 1'b0);
    chk("bypass_off_s", 32'(off_s), 32'd3);
    enhance_en = 1'b1;
    repeat (10) tick(1);

    // async reset mid-frame
    pulse_clear();
    repeat (8) press(2'd1, 1'b1, 1'b0);
    chk("pre_reset_s", 32'(off_s), 32'd12);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("reset_hsv", 32'(hsv_out), 32'd0);
    tick(1);
    rst = 1'b0;
    press(2'd1, 1'b1, 1'b0);
    chk("post_reset_s", 32'(off_s), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
